// File: rtl/cga_sync_separator.sv
// cga_sync_separator
// Separates sync from a 7-bit digital CGA composite stream sampled at 14.318 MHz.
// Regenerates a fixed-width hsync, detects the vertical interval from long
// sync-tip runs, gates the colour-burst window and measures burst swing, and
// tracks line-timing lock.
//
// Ports
//   clk           : system clock (single clock domain)
//   reset         : asynchronous, active-high reset
//   sample_en     : one-clk strobe per composite sample; all state advances on it
//   comp_in[6:0]  : composite level
//   hsync_out     : regenerated horizontal sync, HS_WIDTH samples, active high
//   vsync_out     : vertical sync, active high
//   frame_start   : one-clk pulse on the vsync_out rising edge
//   burst_gate    : high inside the colour-burst window
//   color_present : colour burst seen in the last completed gate
//   sync_lock     : stable line timing detected
//   line_count    : lines since the last vsync (saturating)
module cga_sync_separator #(
  parameter logic [6:0] SYNC_THRESH = 7'd15,
  parameter int         HS_WIDTH    = 64,
  parameter int         HS_MIN      = 16,
  parameter int         VS_MIN      = 256,
  parameter int         LINE_MIN    = 880,
  parameter int         LINE_MAX    = 944,
  parameter int         BURST_START = 8,
  parameter int         BURST_LEN   = 32,
  parameter logic [6:0] BURST_AMP   = 7'd16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic [6:0] comp_in,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       frame_start,
  output logic       burst_gate,
  output logic       color_present,
  output logic       sync_lock,
  output logic [9:0] line_count
);

  localparam logic [9:0] C_SAT       = 10'h3FF;
  localparam logic [9:0] C_HS_LAST   = 10'(HS_WIDTH - 1);
  localparam logic [9:0] C_HS_MIN    = 10'(HS_MIN);
  localparam logic [9:0] C_VS_MIN    = 10'(VS_MIN);
  localparam logic [9:0] C_VS_PRE    = 10'(VS_MIN - 1);
  localparam logic [9:0] C_LINE_MIN  = 10'(LINE_MIN);
  localparam logic [9:0] C_LINE_MAX  = 10'(LINE_MAX);
  localparam logic [9:0] C_BST_FIRST = 10'(BURST_START);
  localparam logic [9:0] C_BST_END   = 10'(BURST_START + BURST_LEN);
  localparam logic [9:0] C_BST_LAST  = 10'(BURST_START + BURST_LEN - 1);

  typedef enum logic {S_BLANK, S_TIP} state_t;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == C_SAT) ? v : v + 10'd1;
  endfunction

  state_t     r_state, w_state_nxt;
  logic       r_tip;
  logic [9:0] r_run_cnt, r_line_timer, r_hs_cnt, r_bcnt;
  logic       r_bact, r_first, r_have_ref;
  logic [2:0] r_good;
  logic [6:0] r_min, r_max;

  logic       w_lead, w_trail, w_accept, w_vs_set, w_good_trail, w_vs_nxt;
  logic       w_lt_sat, w_spacing_ok, w_bact, w_gate_nxt, w_gate_fall;
  logic [9:0] w_bidx;
  logic [6:0] w_min, w_max;

  always_comb begin
    w_state_nxt = r_state;
    w_lead      = 1'b0;
    w_trail     = 1'b0;
    case (r_state)
      S_BLANK: if (r_tip) begin
        w_state_nxt = S_TIP;
        w_lead      = 1'b1;
      end
      S_TIP: if (!r_tip) begin
        w_state_nxt = S_BLANK;
        w_trail     = 1'b1;
      end
      default: w_state_nxt = S_BLANK;
    endcase
  end

  // Once locked, leading edges too early in the line are equalising/serration pulses.
  assign w_accept     = w_lead && ((r_line_timer >= C_LINE_MIN) || !sync_lock);
  assign w_vs_set     = (r_state == S_TIP) && r_tip && (r_run_cnt == C_VS_PRE);
  assign w_good_trail = w_trail && (r_run_cnt >= C_HS_MIN);
  assign w_vs_nxt     = w_vs_set ? 1'b1 :
                        (w_good_trail && (r_run_cnt < C_VS_MIN)) ? 1'b0 : vsync_out;
  assign w_lt_sat     = (r_line_timer == C_SAT);
  assign w_spacing_ok = (r_line_timer >= C_LINE_MIN) && (r_line_timer <= C_LINE_MAX);

  // Burst window: index 0 is the trailing-edge sample itself.
  assign w_bact      = w_good_trail || r_bact;
  assign w_bidx      = w_good_trail ? 10'd0 : r_bcnt;
  assign w_gate_nxt  = w_bact && (w_bidx >= C_BST_FIRST) && (w_bidx < C_BST_END) && !w_vs_nxt;
  assign w_gate_fall = burst_gate && !w_gate_nxt;

  // Running extremes include the current gated sample so the falling-edge
  // decision sees the whole window.
  assign w_min = (r_first || (comp_in < r_min)) ? comp_in : r_min;
  assign w_max = (r_first || (comp_in > r_max)) ? comp_in : r_max;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_BLANK;
      r_tip         <= 1'b0;
      r_run_cnt     <= '0;
      r_line_timer  <= '0;
      r_hs_cnt      <= '0;
      r_bcnt        <= '0;
      r_bact        <= 1'b0;
      r_first       <= 1'b1;
      r_have_ref    <= 1'b0;
      r_good        <= '0;
      hsync_out     <= 1'b0;
      vsync_out     <= 1'b0;
      frame_start   <= 1'b0;
      burst_gate    <= 1'b0;
      color_present <= 1'b0;
      sync_lock     <= 1'b0;
      line_count    <= '0;
    end else begin
      frame_start <= 1'b0;
      if (sample_en) begin
        r_state <= w_state_nxt;
        r_tip   <= (comp_in < SYNC_THRESH);

        if (w_lead)
          r_run_cnt <= '0;
        else if ((r_state == S_TIP) && r_tip)
          r_run_cnt <= sat_inc(r_run_cnt);

        r_line_timer <= w_accept ? 10'd0 : sat_inc(r_line_timer);

        // A restart on the expiry sample keeps hsync high.
        if (w_accept) begin
          hsync_out <= 1'b1;
          r_hs_cnt  <= '0;
        end else if (hsync_out) begin
          if (r_hs_cnt == C_HS_LAST)
            hsync_out <= 1'b0;
          r_hs_cnt <= r_hs_cnt + 10'd1;
        end

        vsync_out   <= w_vs_nxt;
        frame_start <= w_vs_set && !vsync_out;

        if (w_vs_set)
          line_count <= '0;
        else if (w_accept)
          line_count <= sat_inc(line_count);

        // The first accepted edge after losing lock is only a timing reference.
        if (w_accept) begin
          if (!r_have_ref) begin
            r_have_ref <= 1'b1;
            r_good     <= '0;
          end else if (w_spacing_ok) begin
            if (r_good >= 3'd3)
              sync_lock <= 1'b1;
            if (r_good != 3'd4)
              r_good <= r_good + 3'd1;
          end else begin
            sync_lock  <= 1'b0;
            r_good     <= '0;
            r_have_ref <= 1'b0;
          end
        end else if (w_lt_sat) begin
          sync_lock  <= 1'b0;
          r_good     <= '0;
          r_have_ref <= 1'b0;
        end

        burst_gate <= w_gate_nxt;
        if (w_bact) begin
          r_bcnt <= w_bidx + 10'd1;
          r_bact <= (w_bidx < C_BST_LAST);
        end
        r_first <= !burst_gate;
        if (w_gate_fall)
          color_present <= ((w_max - w_min) >= BURST_AMP);
      end
    end
  end

  // Burst extremes are pure data; r_first qualifies them.
  always_ff @(posedge clk) begin
    if (sample_en && burst_gate) begin
      r_min <= w_min;
      r_max <= w_max;
    end
  end

endmodule

// File: tb/tb_cga_sync_separator.sv
// Testbench for cga_sync_separator: randomised composite lines with random
// sample_en gaps, checked every clock against a timestamp-based reference model.
module tb_cga_sync_separator;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_en;
  logic [6:0] comp_in;
  logic       hsync_out, vsync_out, frame_start, burst_gate, color_present, sync_lock;
  logic [9:0] line_count;

  cga_sync_separator dut (
    .clk          (clk),
    .reset        (reset),
    .sample_en    (sample_en),
    .comp_in      (comp_in),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .frame_start  (frame_start),
    .burst_gate   (burst_gate),
    .color_present(color_present),
    .sync_lock    (sync_lock),
    .line_count   (line_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int fs_cnt = 0;
  bit bg_in_win;

  // Reference model state, expressed as sample timestamps.
  int m_n, m_L, m_A, m_T, m_ltref, m_good, m_lc;
  bit m_tip, m_intip, m_Av, m_Tv, m_vs, m_fs, m_hs, m_lock, m_haveref, m_gate, m_color;
  int q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h, expected %0h (sample %0d)", tag, obs, exp, m_n);
    end
  endtask

  function automatic logic [15:0] outs();
    return {hsync_out, vsync_out, frame_start, burst_gate, color_present, sync_lock, line_count};
  endfunction

  function automatic logic [15:0] exp_vec();
    return {m_hs, m_vs, m_fs, m_gate, m_color, m_lock, 10'(m_lc)};
  endfunction

  function automatic void model_reset();
    m_n = 0; m_L = 0; m_A = 0; m_T = 0; m_ltref = 0; m_good = 0; m_lc = 0;
    m_tip = 0; m_intip = 0; m_Av = 0; m_Tv = 0; m_vs = 0; m_fs = 0; m_hs = 0;
    m_lock = 0; m_haveref = 0; m_gate = 0; m_color = 0;
    q.delete();
  endfunction

  task automatic model_step(input logic [6:0] x);
    int lt, rc, k, mx, mn;
    bit lead, trail, acc, vs_set, good_trail, vs_nxt, gate_nxt;
    lt = m_n - m_ltref;
    if (lt > 1023) lt = 1023;
    lead  = !m_intip && m_tip;
    trail = m_intip && !m_tip;
    rc = m_n - m_L - 1;
    if (rc > 1023) rc = 1023;
    acc        = lead && (lt >= 880 || !m_lock);
    vs_set     = m_intip && m_tip && (m_n - m_L == 256);
    m_fs       = vs_set && !m_vs;
    good_trail = trail && rc >= 16;
    vs_nxt     = vs_set ? 1'b1 : (good_trail && rc < 256) ? 1'b0 : m_vs;
    if (acc) begin
      if (!m_haveref) begin
        m_haveref = 1; m_good = 0;
      end else if (lt >= 880 && lt <= 944) begin
        m_good++;
        if (m_good >= 4) m_lock = 1;
      end else begin
        m_lock = 0; m_good = 0; m_haveref = 0;
      end
    end else if (lt == 1023) begin
      m_lock = 0; m_good = 0; m_haveref = 0;
    end
    if (vs_set) m_lc = 0;
    else if (acc && m_lc < 1023) m_lc++;
    if (acc) begin m_Av = 1; m_A = m_n; m_ltref = m_n + 1; end
    m_hs = m_Av && (m_n - m_A) < 64;
    if (lead) begin m_intip = 1; m_L = m_n; end
    else if (trail) m_intip = 0;
    if (good_trail) begin m_Tv = 1; m_T = m_n; end
    k = m_n - m_T;
    gate_nxt = m_Tv && k >= 8 && k < 40 && !vs_nxt;
    if (m_gate) q.push_back(int'(x));
    if (m_gate && !gate_nxt) begin
      mx = q.max()[0];
      mn = q.min()[0];
      m_color = (mx - mn) >= 16;
    end
    if (!gate_nxt) q.delete();
    m_gate = gate_nxt;
    m_vs   = vs_nxt;
    m_tip  = (x < 7'd15);
    m_n++;
  endtask

  task automatic sample(input logic [6:0] x);
    int gaps;
    gaps = int'($urandom_range(0, 1));
    for (int g = 0; g < gaps; g++) begin
      sample_en = 1'b0;
      comp_in   = 7'($urandom_range(0, 127));
      @(posedge clk); #1;
      m_fs = 0;
      check("hold", outs(), exp_vec());
    end
    sample_en = 1'b1;
    comp_in   = x;
    @(posedge clk); #1;
    model_step(x);
    check("strobe", outs(), exp_vec());
    if (frame_start) fs_cnt++;
    sample_en = 1'b0;
  endtask

  // One line: tip at the start, optional burst, optional extra tip at xat.
  task automatic line(input int period, input int tipw, input bit burst, input int xat, input int xw);
    logic [6:0] x;
    for (int i = 0; i < period; i++) begin
      if (i < tipw || (xat >= 0 && i >= xat && i < xat + xw))
        x = 7'($urandom_range(0, 14));
      else if (burst && i >= tipw + 8 && i < tipw + 24)
        x = ((i - tipw - 8) % 2 == 1) ? 7'd59 : 7'd15;
      else
        x = 7'($urandom_range(27, 31));
      sample(x);
      if (xat >= 0 && i > xat && i <= xat + 100 && burst_gate) bg_in_win = 1;
    end
  endtask

  initial begin
    int lc_before;
    int tw[7] = '{4, 12, 20, 40, 40, 40, 300};
    reset = 1'b1; sample_en = 1'b0; comp_in = 7'd29;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", outs(), 16'h0);
    reset = 1'b0;

    // Blank input: nothing must happen; line_timer saturates.
    for (int i = 0; i < 2000; i++) sample(7'd29);
    check("idle_outs", outs(), 16'h0);
    check("idle_lt_sat", dut.r_line_timer, 10'd1023);

    // Normal lines: lock after the 4th good spacing.
    for (int l = 0; l < 6; l++) line(912, 40, 0, -1, 0);
    check("lines_lock", sync_lock, 1'b1);
    check("lines_count", line_count, 10'd6);

    // Burst present, then removed.
    for (int l = 0; l < 2; l++) line(912, 40, 1, -1, 0);
    check("burst_color", color_present, 1'b1);
    for (int l = 0; l < 2; l++) line(912, 40, 0, -1, 0);
    check("bw_color", color_present, 1'b0);

    // Vertical interval: inverted sync lines.
    fs_cnt = 0;
    for (int l = 0; l < 3; l++) line(912, 872, 0, -1, 0);
    check("vs_fs_count", fs_cnt, 1);
    check("vs_high", vsync_out, 1'b1);
    check("vs_line_count", line_count, 10'd0);
    line(912, 40, 0, -1, 0);
    check("vs_cleared", vsync_out, 1'b0);
    check("vs_post_count", line_count, 10'd1);

    // Equalising-pulse rejection while locked.
    lc_before = int'(line_count);
    line(912, 40, 0, 400, 40);
    check("extra_tip_count", line_count, 10'(lc_before + 1));
    check("extra_tip_lock", sync_lock, 1'b1);
    bg_in_win = 0;
    line(912, 40, 0, 400, 5);
    check("glitch_no_gate", bg_in_win, 1'b0);

    // Reset in the middle of hsync_out.
    for (int i = 0; i < 20; i++) sample(7'd0);
    check("pre_rst_hs", hsync_out, 1'b1);
    reset = 1'b1;
    #1;
    check("async_rst_outs", outs(), 16'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    comp_in = 7'd29;
    for (int i = 0; i < 100; i++) sample(7'd29);
    line(912, 40, 0, -1, 0);
    check("post_rst_count", line_count, 10'd1);

    // Randomised lines: spacing, tip widths, bursts and extra tips.
    for (int l = 0; l < 10; l++) begin
      int xat;
      xat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(300, 500)) : -1;
      line(int'($urandom_range(860, 970)), tw[$urandom_range(0, 6)], 1'($urandom_range(0, 1)),
           xat, int'($urandom_range(3, 50)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cga_sync_separator.md
CGA_SYNC_SEPARATOR -- requirements
Module: cga_sync_separator

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- SYNC_THRESH, 7'd15: comp_in below this value is sync tip (black level is 29).
- HS_WIDTH, 64: regenerated hsync_out width, in samples.
- HS_MIN, 16: minimum low-run width, in samples, counted as a valid sync pulse.
- VS_MIN, 256: low-run width, in samples, at which vsync is declared.
- LINE_MIN, 880 and LINE_MAX, 944: accepted hsync spacing window, in samples (nominal 912).
- BURST_START, 8 and BURST_LEN, 32: burst gate offset from sync trailing edge, and gate length, in samples.
- BURST_AMP, 7'd16: minimum peak-to-peak swing inside the gate that counts as colour burst.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: system clock; the block has one clock.
- reset, in, 1: reset, asynchronous and active-high.
- sample_en, in, 1: one-clk strobe per composite sample (14.318 MHz).
- comp_in, in, 7: digital composite level.
- hsync_out, out, 1: regenerated horizontal sync, active high.
- vsync_out, out, 1: vertical sync, active high.
- frame_start, out, 1: one-clk pulse on the vsync_out rising edge.
- burst_gate, out, 1: high while inside the colour-burst window.
- color_present, out, 1: colour burst detected (colour-killer enable when low).
- sync_lock, out, 1: stable line timing detected.
- line_count, out, 10: lines since the last vsync.

Function
REQ-003 All state SHALL advance only on clk edges where sample_en=1; outputs SHALL hold between strobes, except frame_start, which is one clk wide.
REQ-004 tip SHALL be a register loaded with (comp_in < SYNC_THRESH) on each sample_en, so level detection has one sample of latency.
REQ-005 The sync FSM SHALL have two states:
- BLANK: on a sample with tip=1, go to TIP and clear run_cnt.
- TIP: on each sample with tip=1, run_cnt increments, saturating at 1023; on tip=0, go to BLANK (trailing edge).
REQ-006 Leading edge (BLANK->TIP) SHALL be accepted as hsync only if line_timer >= LINE_MIN or sync_lock=0; otherwise it SHALL be ignored (equalising/serration rejection).
REQ-007 On an accepted leading edge:
- hsync_out is asserted for exactly HS_WIDTH samples, then deasserted.
- line_timer restarts at 0.
- line_count increments, saturating at 1023.
REQ-008 line_timer SHALL increment every sample and saturate at 1023.
REQ-009 vsync_out SHALL set on the sample where run_cnt reaches VS_MIN while in TIP, and frame_start SHALL pulse in the same cycle; line_count SHALL be cleared to 0 at that point.
REQ-010 vsync_out SHALL clear on a trailing edge with HS_MIN <= run_cnt < VS_MIN, i.e. the first normal-width hsync after the vertical interval.
REQ-011 A low run shorter than HS_MIN SHALL be treated as a glitch:
- the accepted-hsync and line_timer effects are not reverted, because acceptance happens at the leading edge;
- burst_gate is not started;
- vsync_out is unaffected.
REQ-012 burst_gate SHALL be high for samples BURST_START .. BURST_START+BURST_LEN-1 counted after a trailing edge with run_cnt >= HS_MIN, and SHALL be suppressed while vsync_out=1.
REQ-013 While burst_gate=1, the block SHALL track running min and max of comp_in; both are initialised from the first gated sample.
REQ-014 On the sample burst_gate falls, color_present SHALL load (max - min >= BURST_AMP), computed unsigned in 7 bits with max >= min guaranteed.
REQ-015 sync_lock SHALL set after 4 consecutive accepted hsyncs whose spacing (line_timer value at acceptance) is within LINE_MIN..LINE_MAX.
REQ-016 sync_lock SHALL clear, and the consecutive count SHALL reset, on any of:
- a spacing outside LINE_MIN..LINE_MAX;
- line_timer saturating (no sync).
REQ-017 On a re-lock, the first accepted hsync after sync_lock=0 SHALL start the consecutive count at 0; it is not counted as a good spacing.
REQ-018 If a leading edge and HS_WIDTH expiry fall on the same sample, restart SHALL win and hsync_out SHALL stay high.

Reset
REQ-019 While reset=1, the block SHALL force:
- FSM to BLANK, tip 0;
- run_cnt, line_timer and line_count to 0;
- hsync_out, vsync_out, frame_start, burst_gate, color_present and sync_lock to 0.
REQ-020 Reset deassertion mid-line SHALL accept the first subsequent leading edge unconditionally, because sync_lock=0.

Verification
REQ-021 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset release, then comp_in=29 constant for 2000 samples -> all outputs 0; line_timer saturates; sync_lock stays 0.
- Lines of 912 samples with 40-sample 0-level tips, else 29 -> hsync_out pulses of 64 samples every 912; sync_lock=1 after the 4th good spacing; line_count increments by 1 per line.
- Same lines with 16 burst samples alternating 15/59 at offset 8 -> color_present=1 after the first line; with the burst removed (bw encoding) -> color_present=0 after the next gate.
- 3 lines of inverted sync (low with 40-sample high serrations) -> frame_start single pulse and vsync_out=1 at run_cnt=256; line_count=0; vsync_out clears on the first normal 40-sample tip.
- While locked, an extra 40-sample tip at line_timer=400 -> ignored, with no hsync_out restart and no line_count change; a 5-sample tip -> no burst_gate.
- Assert reset mid-hsync_out -> all outputs 0 immediately; after release, the next tip is accepted and line_count=1.
